// File: rtl/cla_pipe_adder.sv
// Pipelined two-level carry-lookahead adder/subtractor with valid/ready handshakes.
// Operands split into GROUP-bit lookahead blocks; a second lookahead level spans the
// blocks. Pipeline depth STAGES (1..3) moves the register cut between the levels.
// Whole-word propagate/generate outputs let wider adders cascade instances.
module cla_pipe_adder #(
    parameter int WIDTH  = 32,
    parameter int GROUP  = 4,
    parameter int STAGES = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    input  logic             in_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf,
    output logic             out_p,
    output logic             out_g
);
    localparam int NB      = WIDTH / GROUP;
    localparam int BLK_IDX = (STAGES == 3) ? 1 : 0;

    if ((WIDTH % GROUP) != 0) begin : g_bad_width
        $error("cla_pipe_adder: WIDTH must be a multiple of GROUP");
    end
    if (!((GROUP == 2) || (GROUP == 4) || (GROUP == 8))) begin : g_bad_group
        $error("cla_pipe_adder: GROUP must be 2, 4 or 8");
    end
    if ((STAGES < 1) || (STAGES > 3)) begin : g_bad_stages
        $error("cla_pipe_adder: STAGES must be in 1..3");
    end

    // Lookahead generate of a single GROUP-bit block (carry-in independent)
    function automatic logic blk_gen(input logic [GROUP-1:0] p, input logic [GROUP-1:0] g);
        logic acc;
        logic pp;
        acc = 1'b0;
        pp  = 1'b1;
        for (int j = GROUP - 1; j >= 0; j--) begin
            acc = acc | (pp & g[j]);
            pp  = pp & p[j];
        end
        return acc;
    endfunction

    // Second-level lookahead: carry into every block plus carry out of the word
    function automatic logic [NB:0] blk_carries(input logic [NB-1:0] bp, input logic [NB-1:0] bg,
                                                input logic c0);
        logic [NB:0] c;
        logic        acc;
        logic        pp;
        c[0] = c0;
        for (int k = 0; k < NB; k++) begin
            acc = 1'b0;
            pp  = 1'b1;
            for (int j = k; j >= 0; j--) begin
                acc = acc | (pp & bg[j]);
                pp  = pp & bp[j];
            end
            c[k+1] = acc | (pp & c0);
        end
        return c;
    endfunction

    // Whole-word generate from block P/G, carry-in forced to zero
    function automatic logic word_gen(input logic [NB-1:0] bp, input logic [NB-1:0] bg);
        logic acc;
        logic pp;
        acc = 1'b0;
        pp  = 1'b1;
        for (int k = NB - 1; k >= 0; k--) begin
            acc = acc | (pp & bg[k]);
            pp  = pp & bp[k];
        end
        return acc;
    endfunction

    // ---------------- handshake / stage valids ----------------
    logic [STAGES-1:0] v_r;
    logic [STAGES-1:0] v_nxt_s;
    logic              stall_s;
    logic              adv_s;

    assign stall_s   = v_r[STAGES-1] & ~out_ready;
    assign adv_s     = ~stall_s;
    assign in_ready  = adv_s;
    assign out_valid = v_r[STAGES-1];

    // Valid bits shifted one stage forward; entry bit comes from the input port
    always_comb begin
        v_nxt_s    = '0;
        v_nxt_s[0] = in_valid;
        for (int i = 1; i < STAGES; i++) begin
            v_nxt_s[i] = v_r[i-1];
        end
    end

    // Stage valid register: shifts when not stalled, holds otherwise
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            v_r <= '0;
        end else if (adv_s) begin
            v_r <= v_nxt_s;
        end else begin
            v_r <= v_r;
        end
    end

    // ---------------- level A: per-bit conditioning ----------------
    logic [WIDTH-1:0] bm_s;
    logic [WIDTH-1:0] x_a_s;
    logic [WIDTH-1:0] p_a_s;
    logic [WIDTH-1:0] g_a_s;
    logic             c0_a_s;

    // Invert B for subtract, form per-bit propagate/generate/half-sum
    always_comb begin
        bm_s   = in_b ^ {WIDTH{in_sub}};
        p_a_s  = in_a | bm_s;
        g_a_s  = in_a & bm_s;
        x_a_s  = in_a ^ bm_s;
        c0_a_s = in_sub | in_cin;
    end

    // Bit-level pipeline register (only in the path when STAGES == 3)
    logic [WIDTH-1:0] x1_r;
    logic [WIDTH-1:0] p1_r;
    logic [WIDTH-1:0] g1_r;
    logic             c01_r;

    // Capture per-bit terms of an accepted beat
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            x1_r  <= '0;
            p1_r  <= '0;
            g1_r  <= '0;
            c01_r <= 1'b0;
        end else if (adv_s && in_valid) begin
            x1_r  <= x_a_s;
            p1_r  <= p_a_s;
            g1_r  <= g_a_s;
            c01_r <= c0_a_s;
        end else begin
            x1_r  <= x1_r;
            p1_r  <= p1_r;
            g1_r  <= g1_r;
            c01_r <= c01_r;
        end
    end

    // ---------------- level B: block and word lookahead ----------------
    logic [WIDTH-1:0] x_b_s;
    logic [WIDTH-1:0] p_b_s;
    logic [WIDTH-1:0] g_b_s;
    logic             c0_b_s;
    logic [NB-1:0]    bp_s;
    logic [NB-1:0]    bg_s;
    logic [NB:0]      cb_b_s;
    logic             pw_b_s;
    logic             gw_b_s;

    // Select level-B inputs: registered bit terms for 3 stages, direct otherwise
    always_comb begin
        if (STAGES == 3) begin
            x_b_s  = x1_r;
            p_b_s  = p1_r;
            g_b_s  = g1_r;
            c0_b_s = c01_r;
        end else begin
            x_b_s  = x_a_s;
            p_b_s  = p_a_s;
            g_b_s  = g_a_s;
            c0_b_s = c0_a_s;
        end
    end

    // Block P/G, block carry-ins and whole-word P/G
    always_comb begin
        bp_s = '0;
        bg_s = '0;
        for (int k = 0; k < NB; k++) begin
            bp_s[k] = &p_b_s[k*GROUP +: GROUP];
            bg_s[k] = blk_gen(p_b_s[k*GROUP +: GROUP], g_b_s[k*GROUP +: GROUP]);
        end
        cb_b_s = blk_carries(bp_s, bg_s, c0_b_s);
        pw_b_s = &bp_s;
        gw_b_s = word_gen(bp_s, bg_s);
    end

    // Block-level pipeline register (in the path when STAGES >= 2)
    logic [WIDTH-1:0] x2_r;
    logic [WIDTH-1:0] p2_r;
    logic [WIDTH-1:0] g2_r;
    logic [NB:0]      cb2_r;
    logic             pw2_r;
    logic             gw2_r;

    // Capture block carries and bit terms of the beat entering this stage
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            x2_r  <= '0;
            p2_r  <= '0;
            g2_r  <= '0;
            cb2_r <= '0;
            pw2_r <= 1'b0;
            gw2_r <= 1'b0;
        end else if (adv_s && v_nxt_s[BLK_IDX]) begin
            x2_r  <= x_b_s;
            p2_r  <= p_b_s;
            g2_r  <= g_b_s;
            cb2_r <= cb_b_s;
            pw2_r <= pw_b_s;
            gw2_r <= gw_b_s;
        end else begin
            x2_r  <= x2_r;
            p2_r  <= p2_r;
            g2_r  <= g2_r;
            cb2_r <= cb2_r;
            pw2_r <= pw2_r;
            gw2_r <= gw2_r;
        end
    end

    // ---------------- level C: in-block carries and sums ----------------
    logic [WIDTH-1:0] x_c_s;
    logic [WIDTH-1:0] p_c_s;
    logic [WIDTH-1:0] g_c_s;
    logic [NB:0]      cb_c_s;
    logic             pw_c_s;
    logic             gw_c_s;
    logic [WIDTH-1:0] cbit_s;
    logic [WIDTH-1:0] sum_c_s;
    logic             ovf_c_s;

    // Select level-C inputs: registered block terms for 2+ stages, direct otherwise
    always_comb begin
        if (STAGES >= 2) begin
            x_c_s  = x2_r;
            p_c_s  = p2_r;
            g_c_s  = g2_r;
            cb_c_s = cb2_r;
            pw_c_s = pw2_r;
            gw_c_s = gw2_r;
        end else begin
            x_c_s  = x_b_s;
            p_c_s  = p_b_s;
            g_c_s  = g_b_s;
            cb_c_s = cb_b_s;
            pw_c_s = pw_b_s;
            gw_c_s = gw_b_s;
        end
    end

    // Per-bit carries inside each block from its lookahead carry-in, then sums
    always_comb begin
        logic cc;
        cc     = 1'b0;
        cbit_s = '0;
        for (int k = 0; k < NB; k++) begin
            cc = cb_c_s[k];
            for (int j = 0; j < GROUP; j++) begin
                cbit_s[k*GROUP+j] = cc;
                cc = g_c_s[k*GROUP+j] | (p_c_s[k*GROUP+j] & cc);
            end
        end
        sum_c_s = x_c_s ^ cbit_s;
        ovf_c_s = cbit_s[WIDTH-1] ^ cb_c_s[NB];
    end

    // Output register
    logic [WIDTH-1:0] sum_r;
    logic             cout_r;
    logic             ovf_r;
    logic             pw_r;
    logic             gw_r;

    // Load results of the beat entering the last stage; hold during stall
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sum_r  <= '0;
            cout_r <= 1'b0;
            ovf_r  <= 1'b0;
            pw_r   <= 1'b0;
            gw_r   <= 1'b0;
        end else if (adv_s && v_nxt_s[STAGES-1]) begin
            sum_r  <= sum_c_s;
            cout_r <= cb_c_s[NB];
            ovf_r  <= ovf_c_s;
            pw_r   <= pw_c_s;
            gw_r   <= gw_c_s;
        end else begin
            sum_r  <= sum_r;
            cout_r <= cout_r;
            ovf_r  <= ovf_r;
            pw_r   <= pw_r;
            gw_r   <= gw_r;
        end
    end

    assign out_sum  = sum_r;
    assign out_cout = cout_r;
    assign out_ovf  = ovf_r;
    assign out_p    = pw_r;
    assign out_g    = gw_r;

endmodule
